// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI transaction sequencer and peripheral control register bank
//
// Purpose: buffers decoded SPI transactions in a small FIFO, then validates and commits
// each one in arrival order into the control registers that drive the output/PWM logic.
// Optional feature macro: SPI_REG_ERR_CNT_EN (enables the saturating error counter).
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   txn_valid/txn_rw/txn_addr/txn_data decoded transaction, valid for one cycle
//   en_reg_out[15:0]                  {reg1,reg0} output enables
//   en_reg_pwm[15:0]                  {reg3,reg2} PWM mode enables
//   pwm_duty[7:0]                     reg4 PWM duty cycle
//   wr_strobe / rej_strobe            one-cycle pulse per committed / rejected transaction
//   busy                              FSM not idle or FIFO holds entries
//   ovf                               sticky: a transaction was dropped on a full FIFO
//   err_cnt[7:0]                      saturating error counter (zero when feature disabled)

module spi_reg_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_ADDR   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        txn_valid,
    input  logic        txn_rw,
    input  logic [6:0]  txn_addr,
    input  logic [7:0]  txn_data,
    output logic [15:0] en_reg_out,
    output logic [15:0] en_reg_pwm,
    output logic [7:0]  pwm_duty,
    output logic        wr_strobe,
    output logic        rej_strobe,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  err_cnt
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [6:0]  MAX_A = 7'(MAX_ADDR);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT,
        S_REJECT
    } state_t;

    state_t state, state_nxt;

    // FIFO entry layout: {rw, addr[6:0], data[7:0]}
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty;
    logic          push, pop, drop;

    logic          stg_rw;
    logic [6:0]    stg_addr;
    logic [7:0]    stg_data;

    logic [7:0]    reg0, reg1, reg2, reg3, reg4;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = (state == S_LOAD);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push       = txn_valid && (!fifo_full || pop);
    assign drop       = txn_valid && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {txn_rw, txn_addr, txn_data};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_rw   <= 1'b0;
            stg_addr <= '0;
            stg_data <= '0;
        end else if (pop) begin
            {stg_rw, stg_addr, stg_data} <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (stg_rw && (stg_addr <= MAX_A)) ? S_COMMIT : S_REJECT;
            S_COMMIT: state_nxt = fifo_empty ? S_IDLE : S_LOAD;
            S_REJECT: state_nxt = fifo_empty ? S_IDLE : S_LOAD;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign wr_strobe  = (state == S_COMMIT);
    assign rej_strobe = (state == S_REJECT);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // Accepted addresses with no backing register fall through the default arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg0 <= '0;
            reg1 <= '0;
            reg2 <= '0;
            reg3 <= '0;
            reg4 <= '0;
        end else if (state == S_COMMIT) begin
            case (stg_addr)
                7'd0:    reg0 <= stg_data;
                7'd1:    reg1 <= stg_data;
                7'd2:    reg2 <= stg_data;
                7'd3:    reg3 <= stg_data;
                7'd4:    reg4 <= stg_data;
                default: ;
            endcase
        end
    end

    assign en_reg_out = {reg1, reg0};
    assign en_reg_pwm = {reg3, reg2};
    assign pwm_duty   = reg4;

`ifdef SPI_REG_ERR_CNT_EN
    logic [7:0] err_q;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    // A reject and a drop in the same cycle count as two errors.
    assign err_inc = {1'b0, rej_strobe} + {1'b0, drop};
    assign err_sum = {1'b0, err_q} + {7'b0, err_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard testbench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        txn_valid;
    logic        txn_rw;
    logic [6:0]  txn_addr;
    logic [7:0]  txn_data;
    logic [15:0] en_reg_out;
    logic [15:0] en_reg_pwm;
    logic [7:0]  pwm_duty;
    logic        wr_strobe;
    logic        rej_strobe;
    logic        busy;
    logic        ovf;
    logic [7:0]  err_cnt;

`ifdef SPI_REG_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {kind (1=commit,0=reject), addr[6:0], data[7:0]}
    logic [15:0] sb [$];
    logic [7:0]  mr [0:4];
    logic        pending = 1'b0;
    logic [7:0]  exp_err = 8'h00;

    spi_reg_ctrl #(.FIFO_DEPTH(2), .MAX_ADDR(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .txn_valid  (txn_valid),
        .txn_rw     (txn_rw),
        .txn_addr   (txn_addr),
        .txn_data   (txn_data),
        .en_reg_out (en_reg_out),
        .en_reg_pwm (en_reg_pwm),
        .pwm_duty   (pwm_duty),
        .wr_strobe  (wr_strobe),
        .rej_strobe (rej_strobe),
        .busy       (busy),
        .ovf        (ovf),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on each strobe, then checks the register
    // outputs one cycle later against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) mr[i] = 8'h00;
            pending = 1'b0;
        end else begin
            if (pending) begin
                checks++;
                if (en_reg_out !== {mr[1], mr[0]} || en_reg_pwm !== {mr[3], mr[2]} || pwm_duty !== mr[4]) begin
                    errors++;
                    $display("FAIL regs_after_commit: got out=%h pwm=%h duty=%h want out=%h pwm=%h duty=%h",
                             en_reg_out, en_reg_pwm, pwm_duty, {mr[1], mr[0]}, {mr[3], mr[2]}, mr[4]);
                end
                pending = 1'b0;
            end
            if (wr_strobe && rej_strobe) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: got wr=1 rej=1 want at most one");
            end else if (wr_strobe || rej_strobe) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got wr=%b rej=%b want none", wr_strobe, rej_strobe);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    if (wr_strobe !== e[15]) begin
                        errors++;
                        $display("FAIL strobe_kind: got wr=%b want wr=%b (addr %h)", wr_strobe, e[15], e[14:8]);
                    end else if (e[15] && e[14:8] <= 7'd4) begin
                        mr[e[14:8]] = e[7:0];
                        pending = 1'b1;
                    end else if (e[15]) begin
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drive(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                         input logic dropped);
        @(negedge clk);
        txn_valid = 1'b1;
        txn_rw    = rw;
        txn_addr  = addr;
        txn_data  = data;
        if (dropped) begin
            exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
        end else begin
            if (rw && addr <= 7'd4) begin
                sb.push_back({1'b1, addr, data});
            end else begin
                sb.push_back({1'b0, addr, data});
                exp_err = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
            end
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        txn_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got busy=%b pending=%0d want busy=0 pending=0", name, busy, sb.size());
        end
    endtask

    task automatic apply_reset();
        txn_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        exp_err = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (en_reg_out !== 16'h0 || en_reg_pwm !== 16'h0 || pwm_duty !== 8'h0 ||
            busy !== 1'b0 || ovf !== 1'b0 || err_cnt !== 8'h0 || wr_strobe !== 1'b0 || rej_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%h pwm=%h duty=%h busy=%b ovf=%b err=%h want all zero",
                     en_reg_out, en_reg_pwm, pwm_duty, busy, ovf, err_cnt);
        end
    endtask

    task automatic test_single_write();
        logic [3:0] seen;
        drive(1'b1, 7'h00, 8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            txn_valid = 1'b0;
            seen[k] = wr_strobe;
        end
        checks++;
        if (seen !== 4'b1000) begin
            errors++;
            $display("FAIL write_latency: got strobe cycles=%b want 1000", seen);
        end
        wait_idle("single_write");
        checks++;
        if (en_reg_out !== 16'h00A5) begin
            errors++;
            $display("FAIL single_write_out: got %h want 00a5", en_reg_out);
        end
    endtask

    task automatic test_two_writes();
        drive(1'b1, 7'h04, 8'h80, 1'b0);
        release_bus();
        drive(1'b1, 7'h03, 8'h0F, 1'b0);
        release_bus();
        wait_idle("two_writes");
        checks++;
        if (pwm_duty !== 8'h80 || en_reg_pwm !== 16'h0F00) begin
            errors++;
            $display("FAIL two_writes: got duty=%h pwm=%h want 80 0f00", pwm_duty, en_reg_pwm);
        end
    endtask

    task automatic test_read_reject();
        drive(1'b0, 7'h01, 8'hFF, 1'b0);
        release_bus();
        wait_idle("read_reject");
        checks++;
        if (en_reg_out !== 16'h00A5 || err_cnt !== (ERR_EN ? exp_err : 8'h00)) begin
            errors++;
            $display("FAIL read_reject: got out=%h err=%h want 00a5 %h",
                     en_reg_out, err_cnt, ERR_EN ? exp_err : 8'h00);
        end
    endtask

    task automatic test_addr_reject();
        drive(1'b1, 7'h05, 8'h11, 1'b0);
        release_bus();
        wait_idle("addr_reject");
        checks++;
        if (en_reg_out !== 16'h00A5 || en_reg_pwm !== 16'h0F00 || pwm_duty !== 8'h80 ||
            err_cnt !== (ERR_EN ? exp_err : 8'h00)) begin
            errors++;
            $display("FAIL addr_reject: got out=%h pwm=%h duty=%h err=%h want 00a5 0f00 80 %h",
                     en_reg_out, en_reg_pwm, pwm_duty, err_cnt, ERR_EN ? exp_err : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1'b1, 7'h00, 8'h01, 1'b0);
        drive(1'b1, 7'h01, 8'h02, 1'b0);
        drive(1'b1, 7'h02, 8'h03, 1'b0);
        drive(1'b1, 7'h03, 8'h04, 1'b1);
        release_bus();
        wait_idle("back_to_back");
        checks++;
        if (en_reg_out !== 16'h0201 || en_reg_pwm !== 16'h0003 || ovf !== 1'b1 ||
            err_cnt !== (ERR_EN ? exp_err : 8'h00)) begin
            errors++;
            $display("FAIL back_to_back: got out=%h pwm=%h ovf=%b err=%h want 0201 0003 1 %h",
                     en_reg_out, en_reg_pwm, ovf, err_cnt, ERR_EN ? exp_err : 8'h00);
        end
    endtask

    task automatic test_reset_in_commit();
        // Not pushed to the scoreboard: any strobe seen would be flagged.
        @(negedge clk);
        txn_valid = 1'b1;
        txn_rw    = 1'b1;
        txn_addr  = 7'h00;
        txn_data  = 8'hFF;
        @(posedge clk);           // edge N
        #1 txn_valid = 1'b0;
        repeat (3) @(posedge clk); // edge N+3: COMMIT
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_strobe !== 1'b0 || busy !== 1'b0 || en_reg_out !== 16'h0 || en_reg_pwm !== 16'h0 ||
            pwm_duty !== 8'h0 || ovf !== 1'b0 || err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_in_commit: got wr=%b busy=%b out=%h pwm=%h duty=%h ovf=%b err=%h want all zero",
                     wr_strobe, busy, en_reg_out, en_reg_pwm, pwm_duty, ovf, err_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (en_reg_out !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_in_commit: got out=%h busy=%b want 0000 0", en_reg_out, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        txn_valid = 1'b0;
        txn_rw    = 1'b0;
        txn_addr  = 7'h00;
        txn_data  = 8'h00;
        test_reset();
        test_single_write();
        test_two_writes();
        test_read_reject();
        test_addr_reject();
        test_back_to_back();
        test_reset_in_commit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
